// File: rtl/cram_ld_ctl.sv
// cram_ld_ctl: owns the 2K x 84 CRAM port, arbitrating EBOX fetch against diagnostic load/readback (optional write-verify: CRAM_WRVERIFY_EN).
// Latency with ebox_run low: write done at strobe+2 (+4 with CRAM_WRVERIFY_EN), read data and done at strobe+3.
// Backpressure: diag ops park in WAITQ while ebox_run is high; strobes arriving while not IDLE are dropped and set err.
module cram_ld_ctl #(
    parameter int AW = 11,
    parameter int DW = 84,
    parameter int CW = 21
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          ebox_run,
    input  logic [AW-1:0] ebox_adr,
    input  logic          diag_ld,
    input  logic [1:0]    diag_sel,
    input  logic [CW-1:0] diag_data,
    input  logic [AW-1:0] diag_adr,
    input  logic          diag_wr,
    input  logic          diag_rd,
    input  logic [DW-1:0] cram_dout,
    output logic [AW-1:0] cram_adr,
    output logic [DW-1:0] cram_din,
    output logic          cram_we,
    output logic [CW-1:0] diag_rdata,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAITQ = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_RADR  = 3'd3;
    localparam logic [2:0] S_RDAT  = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;
`ifdef CRAM_WRVERIFY_EN
    localparam logic [2:0] S_VADR  = 3'd6;
    localparam logic [2:0] S_VDAT  = 3'd7;
`endif

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic          lat_wr;
    logic [AW-1:0] lat_adr;
    logic [1:0]    lat_sel;
    logic          strobe;
    logic          vfy_bad;
    logic          err_set;

    assign strobe = diag_wr | diag_rd;

`ifdef CRAM_WRVERIFY_EN
    // cram_dout here is the readback of the address presented in VADR
    assign vfy_bad = (state == S_VDAT) && (cram_dout != cram_din);
`else
    assign vfy_bad = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (strobe) begin
                    if (ebox_run)     state_nxt = S_WAITQ;
                    else if (diag_wr) state_nxt = S_WRITE;
                    else              state_nxt = S_RADR;
                end
            end
            S_WAITQ: begin
                if (!ebox_run) state_nxt = lat_wr ? S_WRITE : S_RADR;
            end
`ifdef CRAM_WRVERIFY_EN
            S_WRITE: state_nxt = S_VADR;
            S_VADR:  state_nxt = S_VDAT;
            S_VDAT:  state_nxt = S_FIN;
`else
            S_WRITE: state_nxt = S_FIN;
`endif
            S_RADR:  state_nxt = S_RDAT;
            S_RDAT:  state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Collisions: simultaneous wr+rd, any strobe outside IDLE, staging during the write cycle
    assign err_set = ((state == S_IDLE) && diag_wr && diag_rd)
                   || ((state != S_IDLE) && strobe)
                   || ((state == S_WRITE) && diag_ld)
                   || vfy_bad;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state      <= S_IDLE;
            lat_wr     <= 1'b0;
            lat_adr    <= '0;
            lat_sel    <= '0;
            cram_din   <= '0;
            diag_rdata <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && strobe) begin
                lat_wr  <= diag_wr;
                lat_adr <= diag_adr;
                lat_sel <= diag_sel;
            end
            if (diag_ld && (state != S_WRITE))
                cram_din[int'(diag_sel)*CW +: CW] <= diag_data;
            if (state == S_RDAT)
                diag_rdata <= cram_dout[int'(lat_sel)*CW +: CW];
            if (err_set)
                err <= 1'b1;
        end
    end

    assign cram_adr = ((state == S_IDLE) || (state == S_WAITQ)) ? ebox_adr : lat_adr;
    assign cram_we  = (state == S_WRITE);
    assign done     = (state == S_FIN);
    assign busy     = (state != S_IDLE) && (state != S_FIN);

endmodule

// File: tb/tb_cram_ld_ctl.sv
// Scoreboard bench for cram_ld_ctl: random load/write/read traffic against a reference word store.
module tb_cram_ld_ctl;
    localparam int AW = 11;
    localparam int DW = 84;
    localparam int CW = 21;
`ifdef CRAM_WRVERIFY_EN
    localparam int WLAT = 4;
`else
    localparam int WLAT = 2;
`endif

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic          ebox_run = 1'b0;
    logic [AW-1:0] ebox_adr = '0;
    logic          diag_ld = 1'b0;
    logic [1:0]    diag_sel = '0;
    logic [CW-1:0] diag_data = '0;
    logic [AW-1:0] diag_adr = '0;
    logic          diag_wr = 1'b0;
    logic          diag_rd = 1'b0;
    logic [DW-1:0] cram_dout;
    logic [AW-1:0] cram_adr;
    logic [DW-1:0] cram_din;
    logic          cram_we;
    logic [CW-1:0] diag_rdata;
    logic          busy;
    logic          done;
    logic          err;

    cram_ld_ctl #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .CLK(CLK), .RESETn(RESETn), .ebox_run(ebox_run), .ebox_adr(ebox_adr),
        .diag_ld(diag_ld), .diag_sel(diag_sel), .diag_data(diag_data),
        .diag_adr(diag_adr), .diag_wr(diag_wr), .diag_rd(diag_rd),
        .cram_dout(cram_dout), .cram_adr(cram_adr), .cram_din(cram_din),
        .cram_we(cram_we), .diag_rdata(diag_rdata), .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // CRAM array model: synchronous read, data one cycle after address
    logic [DW-1:0] ram [2048] = '{default: '0};
    bit stuck40 = 1'b0;
    logic [DW-1:0] bit40 = {{(DW-41){1'b0}}, 1'b1, 40'd0};
    always @(posedge CLK) begin
        if (cram_we) ram[cram_adr] <= stuck40 ? (cram_din & ~bit40) : cram_din;
        cram_dout <= ram[cram_adr];
    end

    // Reference state
    logic [DW-1:0] ref_mem [2048] = '{default: '0};
    logic [DW-1:0] stage = '0;
    logic [CW-1:0] last_rd = '0;
    bit            exp_err = 1'b0;
    bit            ebox_rand = 1'b0;
    bit            mon_en = 1'b0;

    typedef struct { bit is_wr; int cyc; logic [CW-1:0] rdata; bit err; } done_t;
    typedef struct { int cyc; logic [AW-1:0] adr; logic [DW-1:0] dat; } wr_t;
    done_t dq[$];
    wr_t   wq[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (cram_we) begin
                tests++;
                if (wq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_we: cram_we=1 adr=%0h expected no write (cycle %0d)", cram_adr, cyc);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("we_cycle", cyc, w.cyc);
                    chk("we_adr", cram_adr, w.adr);
                    chk("we_data", cram_din, w.dat);
                end
            end
            if (done) begin
                tests++;
                if (dq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    done_t d;
                    d = dq.pop_front();
                    chk(d.is_wr ? "wr_done_cycle" : "rd_done_cycle", cyc, d.cyc);
                    chk("rdata_at_done", diag_rdata, d.rdata);
                    chk("err_at_done", err, d.err);
                    chk("busy_at_done", busy, 1'b0);
                end
            end
            if (!busy && !done) chk("idle_route", cram_adr, ebox_adr);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        if (ebox_rand) ebox_adr = AW'($urandom);
    endtask

    task automatic ld(input logic [1:0] sel, input logic [CW-1:0] data);
        diag_ld = 1'b1; diag_sel = sel; diag_data = data;
        stage[sel*CW +: CW] = data;
        step();
        diag_ld = 1'b0;
    endtask

    task automatic wr_model(input logic [AW-1:0] adr, input int done_cyc);
        if (stuck40 && stage[40]) exp_err = 1'b1;
        ref_mem[adr] = stuck40 ? (stage & ~bit40) : stage;
        wq.push_back('{done_cyc - WLAT + 1, adr, stage});
        dq.push_back('{1'b1, done_cyc, last_rd, exp_err});
    endtask

    task automatic do_wr(input logic [AW-1:0] adr);
        diag_wr = 1'b1; diag_adr = adr; diag_sel = 2'($urandom);
        wr_model(adr, cyc + WLAT);
        step();
        diag_wr = 1'b0;
    endtask

    task automatic do_rd(input logic [AW-1:0] adr, input logic [1:0] sel);
        logic [DW-1:0] w;
        diag_rd = 1'b1; diag_adr = adr; diag_sel = sel;
        w = ref_mem[adr];
        last_rd = w[sel*CW +: CW];
        dq.push_back('{1'b0, cyc + 3, last_rd, exp_err});
        step();
        diag_rd = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (dq.size() != 0 || wq.size() != 0); i++) step();
        if (dq.size() != 0 || wq.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d done / %0d writes outstanding, expected 0", dq.size(), wq.size());
            dq.delete(); wq.delete();
        end
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [AW-1:0] coll_adr;
        #2;
        chk("rst_we", cram_we, 1'b0);
        chk("rst_din", cram_din, '0);
        chk("rst_adr", cram_adr, '0);
        chk("rst_rdata", diag_rdata, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        step();
        RESETn = 1'b1;
        step();
        mon_en = 1'b1;

        // Directed load/commit at the top address and chunk readback
        ld(2'd0, 21'h1FFFFF); ld(2'd1, 21'h000001); ld(2'd2, 21'h0AAAAA); ld(2'd3, 21'h155555);
        do_wr(11'h7FF);
        drain();
        do_rd(11'h7FF, 2'd2);
        drain();
        chk("directed_rd", diag_rdata, 21'h0AAAAA);

        // Random traffic, EBOX idle but address bus wandering
        ebox_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = {($urandom_range(0, 1) != 0) ? 7'h7F : 7'h00, 4'($urandom)};
            case ($urandom_range(0, 2))
                0: begin
                    for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                        ld(2'($urandom), CW'($urandom));
                    do_wr(a);
                end
                1: do_rd(a, 2'($urandom));
                default: for (int k = 0; k < int'($urandom_range(1, 3)); k++) step();
            endcase
            drain();
        end
        chk("err_clean_after_random", err, 1'b0);

        // Arbitration: write parked while EBOX runs
        ebox_run = 1'b1;
        ld(2'd1, 21'h012345);
        diag_wr = 1'b1; diag_adr = 11'h2A5;
        ref_mem[11'h2A5] = stage;
        step();
        diag_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            #1;
            chk("arb_route", cram_adr, ebox_adr);
            chk("arb_no_we", cram_we, 1'b0);
            chk("arb_busy", busy, 1'b1);
        end
        ebox_run = 1'b0;
        wq.push_back('{cyc + 1, 11'h2A5, stage});
        dq.push_back('{1'b1, cyc + WLAT, last_rd, exp_err});
        drain();
        do_rd(11'h2A5, 2'd1);
        drain();

        // Collisions: wr+rd together, then a read while busy
        coll_adr = 11'h155;
        ld(2'd3, 21'h0F0F0F);
        diag_wr = 1'b1; diag_rd = 1'b1; diag_adr = coll_adr; diag_sel = 2'd3;
        exp_err = 1'b1;
        wr_model(coll_adr, cyc + WLAT);
        step();
        diag_wr = 1'b0; diag_rd = 1'b0;
        diag_rd = 1'b1; diag_adr = 11'h000;
        step();
        diag_rd = 1'b0;
        drain();
        chk("err_sticky", err, 1'b1);
        do_rd(coll_adr, 2'd3);
        drain();
        chk("err_still_set", err, 1'b1);

        // Reset asserted in the middle of the write cycle
        ebox_rand = 1'b0;
        ebox_adr = '0;
        ld(2'd0, 21'h1ABCDE);
        diag_wr = 1'b1; diag_adr = 11'h333;
        step();
        diag_wr = 1'b0;
        chk("midwr_we_active", cram_we, 1'b1);
        RESETn = 1'b0;
        #1;
        chk("midwr_we_drop", cram_we, 1'b0);
        chk("midwr_busy", busy, 1'b0);
        chk("midwr_done", done, 1'b0);
        chk("midwr_err", err, 1'b0);
        chk("midwr_din", cram_din, '0);
        chk("midwr_rdata", diag_rdata, '0);
        chk("midwr_adr", cram_adr, '0);
        exp_err = 1'b0; stage = '0; last_rd = '0;
        step();
        RESETn = 1'b1;
        step();
        do_rd(11'h333, 2'd0);
        drain();

`ifdef CRAM_WRVERIFY_EN
        // Stuck-at-0 on bit 40 must be caught by the verify readback
        stuck40 = 1'b1;
        for (int k = 0; k < 4; k++) ld(2'(k), '1);
        do_wr(11'h0C3);
        drain();
        chk("verify_err", err, 1'b1);
        stuck40 = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
